// File: rtl/lfsr_rng64.sv
// lfsr_rng64: 64-bit Fibonacci LFSR pseudo-random word generator.
//
// It takes a 64-bit seed once through a valid strobe and then shifts one bit per clock.
// Every STEPS clocks it publishes the current LFSR state as a new word, with a
// one-cycle valid pulse. Feedback polynomial: x^64 + x^63 + x^61 + x^60 + 1 (XOR form).
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous, active-high reset
//   input_tvalid   seed-valid strobe, sampled only while idle
//   seed           seed value, captured with input_tvalid while idle
//   output_tvalid  one-cycle pulse: rnd holds a new word
//   rnd            last published random word (registered)
module lfsr_rng64 #(
  parameter int unsigned STEPS         = 64,
  parameter logic [63:0] ZERO_SEED_SUB = 64'h0000_0000_0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        input_tvalid,
  input  logic [63:0] seed,
  output logic        output_tvalid,
  output logic [63:0] rnd
);

  localparam logic [5:0] LastCnt = 6'(STEPS - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      fsm_q, fsm_d;
  logic [63:0] lfsr_q, lfsr_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] rnd_q, rnd_d;
  logic        vld_q, vld_d;
  logic [63:0] lfsr_next;

  // Taps 63/62/60/59 realise x^64+x^63+x^61+x^60+1.
  assign lfsr_next = {lfsr_q[62:0], lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59]};

  always_comb begin
    fsm_d  = fsm_q;
    lfsr_d = lfsr_q;
    cnt_d  = cnt_q;
    rnd_d  = rnd_q;
    vld_d  = 1'b0;
    unique case (fsm_q)
      StIdle: begin
        if (input_tvalid) begin
          // An all-zero state would lock the LFSR up, so substitute a non-zero value.
          lfsr_d = (seed == 64'd0) ? ZERO_SEED_SUB : seed;
          cnt_d  = 6'd0;
          fsm_d  = StRun;
        end
      end
      StRun: begin
        // Seed inputs are ignored here; only rst can restart the sequence.
        lfsr_d = lfsr_next;
        if (cnt_q == LastCnt) begin
          cnt_d = 6'd0;
          rnd_d = lfsr_next;
          vld_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q  <= StIdle;
      lfsr_q <= 64'd0;
      cnt_q  <= 6'd0;
      rnd_q  <= 64'd0;
      vld_q  <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      lfsr_q <= lfsr_d;
      cnt_q  <= cnt_d;
      rnd_q  <= rnd_d;
      vld_q  <= vld_d;
    end
  end

  assign output_tvalid = vld_q;
  assign rnd           = rnd_q;

endmodule

// File: tb/tb_lfsr_rng64.sv
// tb_lfsr_rng64: directed self-checking bench for lfsr_rng64.
// It drives two instances: STEPS=64, the default, and STEPS=1, which publishes every clock.
module tb_lfsr_rng64;

  logic        clk;
  logic        rst64, tv64, vld64;
  logic [63:0] seed64, rnd64;
  logic        rst1, tv1, vld1;
  logic [63:0] seed1, rnd1;

  int unsigned errors;
  int unsigned checks;
  int unsigned bad;
  logic [63:0] exp_w;

  localparam logic [63:0] NewSeed = 64'h0123_4567_89AB_CDEF;

  lfsr_rng64 #(.STEPS(64)) u_dut64 (
    .clk          (clk),
    .rst          (rst64),
    .input_tvalid (tv64),
    .seed         (seed64),
    .output_tvalid(vld64),
    .rnd          (rnd64)
  );

  lfsr_rng64 #(.STEPS(1)) u_dut1 (
    .clk          (clk),
    .rst          (rst1),
    .input_tvalid (tv1),
    .seed         (seed1),
    .output_tvalid(vld1),
    .rnd          (rnd1)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference step for the x^64+x^63+x^61+x^60+1 Fibonacci LFSR.
  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst64  = 1'b1;
    tv64   = 1'b1;
    seed64 = 64'hFFFF_FFFF_FFFF_FFFF;
    rst1   = 1'b1;
    tv1    = 1'b0;
    seed1  = 64'd0;

    #5;
    check("reset_rnd", rnd64, 64'd0);
    check("reset_vld", 64'(vld64), 64'd0);
    #7 rst64 = 1'b0;  // released at 12 ns

    // Default run, STEPS=64, all-ones seed.
    tick();  // load edge
    check("load_edge_vld", 64'(vld64), 64'd0);
    bad = 0;
    repeat (63) begin
      tick();
      if (vld64 !== 1'b0) bad++;
    end
    check("no_early_pulse", 64'(bad), 64'd0);
    tick();
    check("first_pulse_vld", 64'(vld64), 64'd1);
    check("first_word", rnd64, 64'h0000_0000_0000_0009);

    exp_w = 64'h0000_0000_0000_0009;
    repeat (64) exp_w = lfsr_step(exp_w);

    // Reseed attempt while running must be ignored.
    seed64 = NewSeed;
    tv64   = 1'b0;
    tick();
    check("pulse_one_cycle", 64'(vld64), 64'd0);
    check("rnd_hold", rnd64, 64'h0000_0000_0000_0009);
    tv64 = 1'b1;
    tick();
    tv64 = 1'b0;
    bad  = 0;
    if (vld64 !== 1'b0) bad++;
    repeat (61) begin
      tick();
      if (vld64 !== 1'b0) bad++;
    end
    check("gap_no_pulse", 64'(bad), 64'd0);
    tick();
    check("second_pulse_vld", 64'(vld64), 64'd1);
    check("second_word_ignores_seed", rnd64, exp_w);

    // Asynchronous reset in mid-cycle, between pulses.
    repeat (10) tick();
    #4 rst64 = 1'b1;
    #1;
    check("async_reset_rnd", rnd64, 64'd0);
    check("async_reset_vld", 64'(vld64), 64'd0);
    #2 rst64 = 1'b0;
    bad = 0;
    repeat (70) begin
      tick();
      if (vld64 !== 1'b0) bad++;
    end
    check("no_pulse_without_seed", 64'(bad), 64'd0);
    check("rnd_stays_zero", rnd64, 64'd0);

    // Reload with the new seed after reset.
    seed64 = NewSeed;
    tv64   = 1'b1;
    tick();
    tv64 = 1'b0;
    repeat (63) tick();
    tick();
    exp_w = NewSeed;
    repeat (64) exp_w = lfsr_step(exp_w);
    check("reseed_pulse_vld", 64'(vld64), 64'd1);
    check("reseed_word", rnd64, exp_w);

    // STEPS=1: every state is published and valid stays high.
    seed1 = 64'hFFFF_FFFF_FFFF_FFFF;
    tv1   = 1'b1;
    #2 rst1 = 1'b0;
    tick();  // load edge
    check("s1_load_edge_vld", 64'(vld1), 64'd0);
    check("s1_load_edge_rnd", rnd1, 64'd0);
    tick();
    check("s1_word1_vld", 64'(vld1), 64'd1);
    check("s1_word1", rnd1, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    check("s1_word2", rnd1, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    check("s1_word3", rnd1, 64'hFFFF_FFFF_FFFF_FFF8);
    exp_w = 64'hFFFF_FFFF_FFFF_FFF8;
    bad   = 0;
    for (int w = 4; w <= 59; w++) begin
      tick();
      exp_w = lfsr_step(exp_w);
      if (rnd1 !== exp_w || vld1 !== 1'b1) bad++;
    end
    check("s1_words_4_to_59", 64'(bad), 64'd0);
    tick();
    check("s1_word60", rnd1, 64'hF000_0000_0000_0000);
    tick();
    check("s1_word61", rnd1, 64'hE000_0000_0000_0001);
    check("s1_word61_vld", 64'(vld1), 64'd1);

    // Zero seed is replaced by the substitute value.
    #4 rst1 = 1'b1;
    seed1 = 64'd0;
    #2 rst1 = 1'b0;
    tick();  // load edge
    tick();
    check("zero_seed_word1", rnd1, 64'h0000_0000_0000_0002);
    bad = 0;
    repeat (100) begin
      tick();
      if (rnd1 === 64'd0 || vld1 !== 1'b1) bad++;
    end
    check("zero_seed_never_zero", 64'(bad), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
